bellek_birimi: RTL and testbench

- Main memory plus memory-mapped I/O slave sitting directly downstream of the multicycle RV32 core's memory port.
- Single port, shared for instruction fetch and LW/SW data access.
- Asynchronous, word-granular read; synchronous write.
- Two MMIO registers (output and halt) and sticky error/status outputs for bench and board observation.

---
 rtl/bellek_birimi.sv | 121 ++++++++++++
 tb/tb_bellek_birimi.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bellek_birimi.sv
// ============================================================================
// Module   : bellek_birimi
// Brief    : Single-port RAM plus MMIO output/halt registers for the RV32 core.
//            Optional macro BELLEK_YAZ_KORUMA_EN write-protects the low words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bellek_birimi #(
  parameter logic [31:0] BASLANGIC_ADRES = 32'h8000_0000,
  parameter int          BELLEK_SATIR    = 2048,
  parameter logic [31:0] CIKIS_ADRES     = 32'h8000_FFF0,
  parameter logic [31:0] DURDUR_ADRES    = 32'h8000_FFF4,
  parameter int          KORUMA_SATIR    = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bellek_adres,
  output logic [31:0] bellek_oku_veri,
  input  logic [31:0] bellek_yaz_veri,
  input  logic        bellek_yaz,
  output logic [31:0] cikis_veri,
  output logic        cikis_gecerli,
  output logic        durdu,
  output logic        adres_hata,
  output logic [15:0] yazma_sayaci
);

  localparam int          c_IDX_W    = $clog2(BELLEK_SATIR);
  localparam logic [31:0] c_RAM_BAYT = 32'(BELLEK_SATIR * 4);
`ifdef BELLEK_YAZ_KORUMA_EN
  localparam logic        c_KORUMA_EN = 1'b1;
`else
  localparam logic        c_KORUMA_EN = 1'b0;
`endif

  logic [31:0] r_mem [BELLEK_SATIR];

  logic [31:0]        r_cikis_veri;
  logic               r_cikis_gecerli;
  logic               r_durdu;
  logic               r_adres_hata;
  logic [15:0]        r_yazma_sayaci;

  logic [31:0]        w_ofs;
  logic [c_IDX_W-1:0] w_idx;
  logic               w_ram_hit;
  logic               w_cikis_hit;
  logic               w_durdur_hit;
  logic               w_gecersiz;
  logic               w_korumali;
  logic               w_yaz_kabul;
  logic               w_ram_yaz;
  logic [31:0]        w_oku_veri;

  // The >= test keeps addresses below the base from wrapping into range.
  assign w_ofs        = bellek_adres - BASLANGIC_ADRES;
  assign w_idx        = w_ofs[c_IDX_W+1:2];
  assign w_ram_hit    = (bellek_adres >= BASLANGIC_ADRES) && (w_ofs < c_RAM_BAYT) &&
                        (bellek_adres[1:0] == 2'b00);
  assign w_cikis_hit  = (bellek_adres == CIKIS_ADRES);
  assign w_durdur_hit = (bellek_adres == DURDUR_ADRES);
  assign w_gecersiz   = !(w_ram_hit || w_cikis_hit || w_durdur_hit);
  assign w_korumali   = c_KORUMA_EN && (32'(w_idx) < 32'(KORUMA_SATIR));
  assign w_yaz_kabul  = bellek_yaz && !r_durdu && !rst;
  assign w_ram_yaz    = w_yaz_kabul && w_ram_hit && !w_korumali;

  always_comb begin
    w_oku_veri = 32'h0000_0000;
    if (w_ram_hit)
      w_oku_veri = r_mem[w_idx];
    else if (w_cikis_hit)
      w_oku_veri = r_cikis_veri;
    else if (w_durdur_hit)
      w_oku_veri = {31'b0, r_durdu};
  end

  // RAM has no reset so a preloaded program image survives rst.
  always_ff @(posedge clk) begin
    if (w_ram_yaz)
      r_mem[w_idx] <= bellek_yaz_veri;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cikis_veri    <= 32'h0000_0000;
      r_cikis_gecerli <= 1'b0;
      r_durdu         <= 1'b0;
      r_adres_hata    <= 1'b0;
      r_yazma_sayaci  <= 16'h0000;
    end else begin
      r_cikis_gecerli <= 1'b0;
      if (w_gecersiz)
        r_adres_hata <= 1'b1;
      if (w_yaz_kabul) begin
        if (w_ram_hit) begin
          if (w_korumali)
            r_adres_hata <= 1'b1;
          else if (r_yazma_sayaci != 16'hFFFF)
            r_yazma_sayaci <= r_yazma_sayaci + 16'd1;
        end
        if (w_cikis_hit) begin
          r_cikis_veri    <= bellek_yaz_veri;
          r_cikis_gecerli <= 1'b1;
        end
        if (w_durdur_hit && bellek_yaz_veri[0])
          r_durdu <= 1'b1;
      end
    end
  end

  assign bellek_oku_veri = w_oku_veri;
  assign cikis_veri      = r_cikis_veri;
  assign cikis_gecerli   = r_cikis_gecerli;
  assign durdu           = r_durdu;
  assign adres_hata      = r_adres_hata;
  assign yazma_sayaci    = r_yazma_sayaci;

endmodule

`default_nettype wire

// File: tb/tb_bellek_birimi.sv
// ============================================================================
// Module   : tb_bellek_birimi
// Brief    : Directed plus random checks of bellek_birimi against a word-level
//            model. Honours BELLEK_YAZ_KORUMA_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bellek_birimi;

  localparam logic [31:0] c_BAZ    = 32'h8000_0000;
  localparam int          c_SATIR  = 2048;
  localparam logic [31:0] c_CIKIS  = 32'h8000_FFF0;
  localparam logic [31:0] c_DURDUR = 32'h8000_FFF4;
  localparam int          c_KORUMA = 256;

  logic        clk;
  logic        rst;
  logic [31:0] bellek_adres;
  logic [31:0] bellek_oku_veri;
  logic [31:0] bellek_yaz_veri;
  logic        bellek_yaz;
  logic [31:0] cikis_veri;
  logic        cikis_gecerli;
  logic        durdu;
  logic        adres_hata;
  logic [15:0] yazma_sayaci;

  bellek_birimi dut (
    .clk            (clk),
    .rst            (rst),
    .bellek_adres   (bellek_adres),
    .bellek_oku_veri(bellek_oku_veri),
    .bellek_yaz_veri(bellek_yaz_veri),
    .bellek_yaz     (bellek_yaz),
    .cikis_veri     (cikis_veri),
    .cikis_gecerli  (cikis_gecerli),
    .durdu          (durdu),
    .adres_hata     (adres_hata),
    .yazma_sayaci   (yazma_sayaci)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vektor = 0;
  int n_hata   = 0;

  // Reference state: RAM words with a known-bit, plus the architectural registers.
  logic [31:0] m_mem     [c_SATIR];
  bit          m_bilinen [c_SATIR];
  logic [31:0] m_cikis;
  logic        m_gecerli;
  logic        m_durdu;
  logic        m_hata;
  int          m_sayac;

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                         input logic [31:0] beklenen);
    n_vektor++;
    if (gozlenen !== beklenen) begin
      n_hata++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", etiket, gozlenen, beklenen, $time);
    end
  endtask

  function automatic bit ram_mi(input logic [31:0] a);
    longint ofs;
    ofs = longint'(a) - longint'(c_BAZ);
    return (ofs >= 0) && (ofs < 4 * c_SATIR) && (a % 4 == 0);
  endfunction

  function automatic int indeks(input logic [31:0] a);
    return int'((a - c_BAZ) / 4);
  endfunction

  function automatic bit korumali(input int i);
`ifdef BELLEK_YAZ_KORUMA_EN
    return i < c_KORUMA;
`else
    return (i < 0);
`endif
  endfunction

  task automatic model_sifirla();
    m_cikis   = 32'h0;
    m_gecerli = 1'b0;
    m_durdu   = 1'b0;
    m_hata    = 1'b0;
    m_sayac   = 0;
  endtask

  task automatic model_guncelle(input logic [31:0] a, input logic [31:0] d,
                                input logic y, input logic r);
    bit gecersiz;
    if (r) begin
      model_sifirla();
      return;
    end
    gecersiz  = !(ram_mi(a) || a == c_CIKIS || a == c_DURDUR);
    m_gecerli = 1'b0;
    if (gecersiz) m_hata = 1'b1;
    if (y && !m_durdu) begin
      if (ram_mi(a)) begin
        if (korumali(indeks(a))) begin
          m_hata = 1'b1;
        end else begin
          m_mem[indeks(a)]     = d;
          m_bilinen[indeks(a)] = 1'b1;
          if (m_sayac < 65535) m_sayac++;
        end
      end else if (a == c_CIKIS) begin
        m_cikis   = d;
        m_gecerli = 1'b1;
      end else if (a == c_DURDUR && d[0]) begin
        m_durdu = 1'b1;
      end
    end
  endtask

  // One clock: drive, check combinational read and registered outputs, then advance model.
  task automatic adim(input logic [31:0] a, input logic [31:0] d, input logic y,
                      input logic r);
    bellek_adres    = a;
    bellek_yaz_veri = d;
    bellek_yaz      = y;
    rst             = r;
    #1;
    if (ram_mi(a)) begin
      if (m_bilinen[indeks(a)]) kontrol("oku_ram", bellek_oku_veri, m_mem[indeks(a)]);
    end else if (a == c_CIKIS) begin
      kontrol("oku_cikis", bellek_oku_veri, m_cikis);
    end else if (a == c_DURDUR) begin
      kontrol("oku_durdur", bellek_oku_veri, {31'b0, m_durdu});
    end else begin
      kontrol("oku_gecersiz", bellek_oku_veri, 32'h0);
    end
    kontrol("cikis_veri", cikis_veri, m_cikis);
    kontrol("cikis_gecerli", {31'b0, cikis_gecerli}, {31'b0, m_gecerli});
    kontrol("durdu", {31'b0, durdu}, {31'b0, m_durdu});
    kontrol("adres_hata", {31'b0, adres_hata}, {31'b0, m_hata});
    kontrol("yazma_sayaci", {16'b0, yazma_sayaci}, 32'(m_sayac));
    @(posedge clk);
    model_guncelle(a, d, y, r);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rastgele_adres();
    int s;
    s = int'($urandom_range(0, 11));
    case (s)
      0, 1:    return c_BAZ + 4 * $urandom_range(0, 15);
      2:       return c_BAZ + 4 * $urandom_range(250, 260);
      3:       return c_BAZ + 4 * (c_SATIR - 1);
      4:       return c_BAZ + 4 * c_SATIR;
      5:       return c_BAZ - 4;
      6:       return c_BAZ + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
      7, 8:    return c_CIKIS;
      9:       return c_DURDUR;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    for (int i = 0; i < c_SATIR; i++) m_bilinen[i] = 1'b0;
    model_sifirla();
    bellek_adres    = c_BAZ;
    bellek_yaz_veri = 32'h0;
    bellek_yaz      = 1'b0;
    rst             = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Preload word 0, then reset twice more: the word must survive.
    adim(c_BAZ, 32'h0050_0093, 1'b1, 1'b0);
    adim(c_BAZ, 32'h0, 1'b0, 1'b1);
    adim(c_BAZ, 32'h0, 1'b0, 1'b1);
    adim(c_BAZ, 32'h0, 1'b0, 1'b0);
`ifndef BELLEK_YAZ_KORUMA_EN
    #1 kontrol("preload_word0", bellek_oku_veri, 32'h0050_0093);
`endif

    // Read-during-write returns old word; new value next cycle.
    adim(32'h8000_0010, 32'h1111_1111, 1'b1, 1'b0);
    adim(32'h8000_0400, 32'hDEAD_BEEF, 1'b1, 1'b0);
    adim(32'h8000_0400, 32'h0, 1'b0, 1'b0);
    #1 kontrol("rdw_new_value", bellek_oku_veri, 32'hDEAD_BEEF);

    // Back-to-back CIKIS writes: two consecutive pulses.
    adim(c_CIKIS, 32'h0000_002A, 1'b1, 1'b0);
    adim(c_CIKIS, 32'h0000_002A, 1'b1, 1'b0);
    adim(c_CIKIS, 32'h0, 1'b0, 1'b0);
    adim(c_CIKIS, 32'h0, 1'b0, 1'b0);

    // Halt writing 0 has no effect; writing 1 freezes all writes.
    adim(c_DURDUR, 32'h0, 1'b1, 1'b0);
    adim(c_DURDUR, 32'h1, 1'b1, 1'b0);
    adim(32'h8000_0010, 32'h1, 1'b1, 1'b0);
    adim(c_CIKIS, 32'h55, 1'b1, 1'b0);
    adim(32'h8000_0010, 32'h0, 1'b0, 1'b0);
    adim(c_DURDUR, 32'h0, 1'b0, 1'b1);
    adim(c_DURDUR, 32'h0, 1'b0, 1'b0);

    // Misaligned read and out-of-range write set the sticky error.
    adim(32'h8000_0002, 32'h0, 1'b0, 1'b0);
    adim(32'h9000_0000, 32'hCAFE_F00D, 1'b1, 1'b0);
    adim(32'h8000_0000, 32'h0, 1'b0, 1'b0);
    adim(32'h8000_0004, 32'h0, 1'b0, 1'b0);

    // Protection boundary: index 0 and 255 vs 256.
    adim(c_DURDUR, 32'h0, 1'b0, 1'b1);
    adim(32'h8000_0000, 32'h1234_5678, 1'b1, 1'b0);
    adim(32'h8000_03FC, 32'h0BAD_0BAD, 1'b1, 1'b0);
    adim(32'h8000_0400, 32'h8765_4321, 1'b1, 1'b0);
    adim(32'h8000_0000, 32'h0, 1'b0, 1'b0);
    adim(32'h8000_0400, 32'h0, 1'b0, 1'b0);

    // Random phase.
    for (int n = 0; n < 600; n++) begin
      a = rastgele_adres();
      d = $urandom;
      if (a == c_DURDUR && $urandom_range(0, 3) != 0) d[0] = 1'b0;
      adim(a, d, 1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vektor, n_hata);
    $finish;
  end

endmodule

`default_nettype wire
